// File: rtl/port_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : port_pkg                                                    |
// | Purpose  : Shared constants for the router-port flit path. The flit    |
// |            width and the default elastic-buffer sizing are used by     |
// |            port_bp_buffer and by the port converters.                  |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package port_pkg;

  // Router-port flit width in bits.
  localparam int PORT_FLIT_W    = 64;

  // Default elastic buffer geometry: DEPTH entries, with SLACK entries
  // reserved for flits the source may still send after backpressure rises.
  localparam int PORT_BUF_DEPTH = 16;
  localparam int PORT_BUF_SLACK = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int port_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : port_pkg
`default_nettype wire

// File: rtl/port_fifo_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : port_fifo_ram                                               |
// | Purpose  : Simple dual-port storage for the port elastic buffer. One   |
// |            clock, one write port, one read port with a registered      |
// |            output. No reset, so it can map onto distributed RAM.       |
// | Ports    : clk      - clock                                            |
// |            wr_en    - write strobe                                     |
// |            wr_addr  - write address                                    |
// |            wr_data  - write data                                       |
// |            rd_en    - read strobe; loads rd_data from mem[rd_addr]     |
// |            rd_addr  - read address                                     |
// |            rd_data  - registered read data, held while rd_en is low    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module port_fifo_ram #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Read and write share one non-blocking block: when both ports hit the
  // same entry in one cycle (buffer full, push and pop together), the read
  // returns the old contents, which is the flit being popped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      r_rd_data <= mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule : port_fifo_ram
`default_nettype wire

// File: rtl/port_bp_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : port_bp_buffer                                              |
// | Purpose  : Elastic buffer on the router-port flit interface. Absorbs   |
// |            flits still in flight after D_BP rises and re-issues them   |
// |            under downstream Q_BP backpressure, without dropping data   |
// |            as long as the source honours D_BP within SLACK cycles.     |
// | Ports    : CLK      - sole clock                                       |
// |            RST      - asynchronous active-high reset                   |
// |            D        - input flit                                       |
// |            D_VALID  - input flit valid (every valid cycle is a write)  |
// |            D_BP     - registered backpressure to the source            |
// |            Q        - output flit                                      |
// |            Q_VALID  - output flit valid, one cycle per flit            |
// |            Q_BP     - backpressure from downstream                     |
// |            LEVEL    - current occupancy                                |
// |            OVERFLOW - sticky, set when a flit is dropped               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module port_bp_buffer
  import port_pkg::*;
#(
  parameter int WIDTH = PORT_FLIT_W,
  parameter int DEPTH = PORT_BUF_DEPTH,
  parameter int SLACK = PORT_BUF_SLACK
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       D,
  input  logic                   D_VALID,
  output logic                   D_BP,
  output logic [WIDTH-1:0]       Q,
  output logic                   Q_VALID,
  input  logic                   Q_BP,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = port_level_w(DEPTH);

  localparam logic [c_cw-1:0] c_depth     = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_bp_thresh = c_cw'(DEPTH - SLACK);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

  logic [c_aw-1:0]  r_wp;
  logic [c_aw-1:0]  r_rp;
  logic [c_cw-1:0]  r_count;
  logic [c_cw-1:0]  w_count_next;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             r_q_valid;
  logic             r_q_loaded;
  logic             r_d_bp;
  logic             r_overflow;
  logic [WIDTH-1:0] w_rd_data;

  // Pop is decided in the same cycle from Q_BP. Push is allowed into a
  // full buffer only when a pop frees an entry in the same cycle.
  assign w_pop  = (r_count != '0) & ~Q_BP;
  assign w_push = D_VALID & ((r_count < c_depth) | w_pop);
  assign w_drop = D_VALID & ~w_push;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_cnt_one;
      2'b01:   w_count_next = r_count - c_cnt_one;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers are c_aw bits wide and DEPTH is a power of two, so they wrap
  // from DEPTH-1 to 0 on their own.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_q_valid  <= 1'b0;
      r_q_loaded <= 1'b0;
      r_d_bp     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end
      if (w_pop) begin
        r_rp       <= r_rp + c_ptr_one;
        r_q_loaded <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count   <= w_count_next;
      r_q_valid <= w_pop;
      r_d_bp    <= (w_count_next >= c_bp_thresh);
    end
  end

  // The RAM read register doubles as the Q output register: it loads only
  // on a pop and otherwise holds. Since the RAM has no reset, Q is forced
  // to zero until the first pop after reset.
  port_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (c_aw)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (w_push),
    .wr_addr (r_wp),
    .wr_data (D),
    .rd_en   (w_pop),
    .rd_addr (r_rp),
    .rd_data (w_rd_data)
  );

  assign Q        = r_q_loaded ? w_rd_data : '0;
  assign Q_VALID  = r_q_valid;
  assign D_BP     = r_d_bp;
  assign LEVEL    = r_count;
  assign OVERFLOW = r_overflow;

endmodule : port_bp_buffer
`default_nettype wire

// File: tb/tb_port_bp_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_port_bp_buffer                                           |
// | Purpose  : Self-checking bench for port_bp_buffer. Stimulus pushes     |
// |            each flit it expects to be accepted into a scoreboard       |
// |            queue; a monitor pops and compares on every Q_VALID.        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_port_bp_buffer;

  localparam int c_width = 64;
  localparam int c_depth = 16;
  localparam int c_slack = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic [c_width-1:0] D;
  logic               D_VALID;
  logic               D_BP;
  logic [c_width-1:0] Q;
  logic               Q_VALID;
  logic               Q_BP;
  logic [4:0]         LEVEL;
  logic               OVERFLOW;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;

  logic [c_width-1:0] exp_q [$];

  port_bp_buffer #(
    .WIDTH (c_width),
    .DEPTH (c_depth),
    .SLACK (c_slack)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .D        (D),
    .D_VALID  (D_VALID),
    .D_BP     (D_BP),
    .Q        (Q),
    .Q_VALID  (Q_VALID),
    .Q_BP     (Q_BP),
    .LEVEL    (LEVEL),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every output flit must match the oldest expected.
  always @(negedge CLK) begin
    if (!RST && Q_VALID) begin
      checks++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL q_unexpected: got Q=%h, required no flit", Q);
      end else begin
        logic [c_width-1:0] e;
        e = exp_q.pop_front();
        if (Q !== e) begin
          failures++;
          $display("FAIL q_data: got %h, required %h", Q, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one flit for one cycle; queue it if it should be accepted.
  task automatic send(input logic [c_width-1:0] data, input bit accept);
    D       = data;
    D_VALID = 1'b1;
    if (accept) exp_q.push_back(data);
    step();
    D_VALID = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then a few idle cycles to catch extras.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d flits pending, required 0", name, exp_q.size());
    end
    repeat (3) step();
  endtask

  initial begin
    int  base;
    bit  lvl_ok;
    bit  bp_ok;

    RST     = 1'b1;
    D       = '0;
    D_VALID = 1'b0;
    Q_BP    = 1'b0;
    repeat (3) @(posedge CLK);
    #4 RST = 1'b0;
    #1;

    // Reset state
    chk("rst_q_valid",  Q_VALID,  1'b0);
    chk("rst_q",        Q,        64'd0);
    chk("rst_d_bp",     D_BP,     1'b0);
    chk("rst_level",    LEVEL,    5'd0);
    chk("rst_overflow", OVERFLOW, 1'b0);

    // Single flit: valid two cycles after D_VALID
    step();
    send(64'h0123_4567_89AB_CDEF, 1'b1);
    chk("single_lat_t1_valid", Q_VALID, 1'b0);
    chk("single_lat_t1_level", LEVEL, 5'd1);
    step();
    chk("single_t2_valid", Q_VALID, 1'b1);
    chk("single_t2_q",     Q, 64'h0123_4567_89AB_CDEF);
    chk("single_level",    LEVEL, 5'd0);
    chk("single_overflow", OVERFLOW, 1'b0);
    step();

    // Streaming: 100 back-to-back flits
    base   = out_cnt;
    lvl_ok = 1'b1;
    bp_ok  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      D       = 64'(i + 1);
      D_VALID = 1'b1;
      exp_q.push_back(64'(i + 1));
      step();
      if (LEVEL > 5'd1) lvl_ok = 1'b0;
      if (D_BP)         bp_ok  = 1'b0;
    end
    D_VALID = 1'b0;
    drain("stream", 20);
    chk("stream_level_le1", lvl_ok, 1'b1);
    chk("stream_no_d_bp",   bp_ok,  1'b1);
    chk("stream_count",     64'(out_cnt - base), 64'd100);
    chk("stream_level_end", LEVEL, 5'd0);

    // Fill to backpressure with Q_BP held
    Q_BP = 1'b1;
    for (int i = 0; i < 11; i++) send(64'hF000_0000 + 64'(i), 1'b1);
    chk("fill11_level", LEVEL, 5'd11);
    chk("fill11_d_bp",  D_BP,  1'b0);
    send(64'hF000_0000 + 64'd11, 1'b1);
    chk("fill12_level", LEVEL, 5'd12);
    chk("fill12_d_bp",  D_BP,  1'b1);
    for (int i = 12; i < 16; i++) send(64'hF000_0000 + 64'(i), 1'b1);
    chk("fill16_level",    LEVEL,    5'd16);
    chk("fill16_overflow", OVERFLOW, 1'b0);

    // Full with simultaneous push and pop
    base = out_cnt;
    Q_BP = 1'b0;
    send(64'hF000_0010, 1'b1);
    chk("fullpp_level",    LEVEL,    5'd16);
    chk("fullpp_overflow", OVERFLOW, 1'b0);
    drain("fullpp", 40);
    chk("fullpp_count", 64'(out_cnt - base), 64'd17);
    chk("fullpp_d_bp_fall", D_BP, 1'b0);

    // Overflow: refill, then push into a full buffer
    Q_BP = 1'b1;
    for (int i = 0; i < 16; i++) send(64'hA000 + 64'(i), 1'b1);
    chk("ovf_pre_level", LEVEL, 5'd16);
    send(64'hDEAD_BEEF, 1'b0);
    chk("ovf_level",    LEVEL,    5'd16);
    chk("ovf_overflow", OVERFLOW, 1'b1);
    base = out_cnt;
    Q_BP = 1'b0;
    drain("ovf", 40);
    chk("ovf_count",    64'(out_cnt - base), 64'd16);
    chk("ovf_sticky",   OVERFLOW, 1'b1);
    chk("ovf_q_hold",   Q, 64'hA00F);

    // Reset mid-stream
    Q_BP = 1'b1;
    for (int i = 0; i < 7; i++) send(64'hC000 + 64'(i), 1'b1);
    chk("mid_level", LEVEL, 5'd7);
    #2 RST = 1'b1;
    #1;
    chk("arst_q_valid",  Q_VALID,  1'b0);
    chk("arst_q",        Q,        64'd0);
    chk("arst_level",    LEVEL,    5'd0);
    chk("arst_overflow", OVERFLOW, 1'b0);
    chk("arst_d_bp",     D_BP,     1'b0);
    exp_q.delete();
    @(posedge CLK);
    #3 RST = 1'b0;
    Q_BP = 1'b0;
    step();
    send(64'h5555_AAAA_1234_5678, 1'b1);
    chk("post_rst_t1_valid", Q_VALID, 1'b0);
    step();
    chk("post_rst_t2_valid", Q_VALID, 1'b1);
    chk("post_rst_t2_q",     Q, 64'h5555_AAAA_1234_5678);
    drain("post_rst", 10);
    chk("post_rst_level", LEVEL, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_port_bp_buffer
`default_nettype wire
